// File: rtl/rsff_chk_pkg.sv
// rtl/rsff_chk_pkg.sv - shared types, LFSR constants and vector decode for the RSFF stimulus checker
package rsff_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  localparam int D_BIT   = 0;
  localparam int RST_LSB = 1;
  localparam int RST_W   = 3;
  localparam int SET_LSB = 4;
  localparam int SET_W   = 3;

  typedef struct packed {
    logic d;
    logic set_n;
    logic reset_n;
  } vec_t;

  localparam vec_t VEC_IDLE = '{d: 1'b0, set_n: 1'b1, reset_n: 1'b1};
  localparam vec_t VEC_INIT = '{d: 1'b0, set_n: 1'b1, reset_n: 1'b0};

  // Controls are asserted when their whole field is zero, so each fires on 1/8 of vectors.
  function automatic vec_t decode_vec(input logic [6:0] s);
    vec_t v;
    v.d       = s[D_BIT];
    v.reset_n = |s[RST_LSB +: RST_W];
    v.set_n   = |s[SET_LSB +: SET_W];
    return v;
  endfunction

  function automatic logic golden_q(input vec_t v);
    if (!v.reset_n) return 1'b0;
    if (!v.set_n)   return 1'b1;
    return v.d;
  endfunction

endpackage

// File: rtl/rsff_stim_checker_if.sv
// rtl/rsff_stim_checker_if.sv - pin bundle between the checker and the RSFF cell under test
interface rsff_stim_checker_if;
  logic dut_d;
  logic dut_set_n;
  logic dut_reset_n;
  logic dut_q;

  modport master (output dut_d, output dut_set_n, output dut_reset_n, input dut_q);
  modport slave  (input dut_d, input dut_set_n, input dut_reset_n, output dut_q);
endinterface

// File: rtl/rsff_lfsr16.sv
// rtl/rsff_lfsr16.sv - 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with load and enable
module rsff_lfsr16
  import rsff_chk_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] lfsr_state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_state <= RESET_VAL;
    end else if (load) begin
      lfsr_state <= seed;
    end else if (en) begin
      lfsr_state <= {lfsr_state[14:0], ^(lfsr_state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/rsff_stim_checker.sv
// rtl/rsff_stim_checker.sv - RSFF stimulus driver and response checker; RSFF_CHK_FIRST_ERR_EN builds first-error capture
module rsff_stim_checker
  import rsff_chk_pkg::*;
#(
  parameter int          NUM_VECS  = 256,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED,
  parameter int          ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  rsff_stim_checker_if.master  pins,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [15:0]          vec_count,
  output logic [15:0]          first_err_idx
);

  localparam logic [15:0]      LAST_IDX = 16'(NUM_VECS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t      state, state_nxt;
  logic        accept;
  logic        issue;
  logic        mismatch;
  logic        chk_pend;
  logic        exp_q;
  vec_t        drv;
  vec_t        vec;
  logic [15:0] lfsr_q;
  logic        unused_lfsr_bits;

  rsff_lfsr16 #(.RESET_VAL(LFSR_SEED)) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .en         (issue),
    .load       (accept),
    .seed       (LFSR_SEED),
    .lfsr_state (lfsr_q)
  );

  assign unused_lfsr_bits = ^lfsr_q[15:7];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN:     if (vec_count == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign issue    = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  // Vector 0 is a plain reset so the cell leaves X before any comparison matters.
  assign vec      = (vec_count == 16'd0) ? VEC_INIT : decode_vec(lfsr_q[6:0]);
  assign mismatch = chk_pend && (pins.dut_q !== exp_q);

  assign pins.dut_d       = drv.d;
  assign pins.dut_set_n   = drv.set_n;
  assign pins.dut_reset_n = drv.reset_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drv       <= VEC_IDLE;
      exp_q     <= 1'b0;
      chk_pend  <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        drv       <= VEC_IDLE;
        chk_pend  <= 1'b0;
        vec_count <= '0;
        err_count <= '0;
        done      <= 1'b0;
        pass      <= 1'b0;
      end else begin
        chk_pend <= issue;
        if (issue) begin
          drv       <= vec;
          exp_q     <= golden_q(vec);
          vec_count <= vec_count + 16'd1;
        end else begin
          drv <= VEC_IDLE;
        end
        if (mismatch && (err_count != ERR_MAX)) begin
          err_count <= err_count + ERR_W'(1);
        end
        // The last check lands on the DRAIN edge, so err_count is final here.
        if (state == DONE) begin
          done <= 1'b1;
          pass <= (err_count == '0);
        end
      end
    end
  end

`ifdef RSFF_CHK_FIRST_ERR_EN
  logic [15:0] chk_idx;
  logic [15:0] first_idx_q;
  logic        first_seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_idx     <= '0;
      first_idx_q <= '0;
      first_seen  <= 1'b0;
    end else if (accept) begin
      first_idx_q <= '0;
      first_seen  <= 1'b0;
    end else begin
      if (issue) chk_idx <= vec_count;
      if (mismatch && !first_seen) begin
        first_seen  <= 1'b1;
        first_idx_q <= chk_idx;
      end
    end
  end

  assign first_err_idx = first_idx_q;
`else
  assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_rsff_stim_checker.sv
// tb/tb_rsff_stim_checker.sv - directed bench for rsff_stim_checker against behavioural RSFF cells
module tb_rsff_stim_checker;

  localparam int          NV   = 16;
  localparam int          NVB  = 64;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef RSFF_CHK_FIRST_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  rsff_stim_checker_if pins_a ();
  rsff_stim_checker_if pins_b ();

  logic        busy_a, done_a, pass_a;
  logic [7:0]  err_a;
  logic [15:0] vcnt_a, first_a;
  logic        busy_b, done_b, pass_b;
  logic [1:0]  err_b;
  logic [15:0] vcnt_b, first_b;

  rsff_stim_checker #(.NUM_VECS(NV), .LFSR_SEED(SEED), .ERR_W(8)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .pins(pins_a.master),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .vec_count(vcnt_a), .first_err_idx(first_a)
  );

  rsff_stim_checker #(.NUM_VECS(NVB), .LFSR_SEED(SEED), .ERR_W(2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .pins(pins_b.master),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .vec_count(vcnt_b), .first_err_idx(first_b)
  );

  // Cell modes: 0 ideal, 1 q stuck at 0, 2 set beats reset, 3 q inverted from vector 7.
  int   mode = 0;
  int   edge_no = 0;
  logic q_cell;

  always @(negedge clk or negedge pins_a.dut_reset_n or negedge pins_a.dut_set_n) begin
    if (mode == 2) begin
      if (!pins_a.dut_set_n)        q_cell <= 1'b1;
      else if (!pins_a.dut_reset_n) q_cell <= 1'b0;
      else                          q_cell <= pins_a.dut_d;
    end else begin
      if (!pins_a.dut_reset_n)      q_cell <= 1'b0;
      else if (!pins_a.dut_set_n)   q_cell <= 1'b1;
      else                          q_cell <= pins_a.dut_d;
    end
  end

  // Vector k is on the pins while edge_no == k+1.
  always @(posedge clk) edge_no <= start_a ? 0 : edge_no + 1;

  assign pins_a.dut_q = (mode == 1) ? 1'b0 :
                        (mode == 3 && edge_no >= 8) ? ~q_cell : q_cell;
  assign pins_b.dut_q = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {d, set_n, reset_n}.
  function automatic logic [2:0] vec_of(input int k);
    logic [15:0] s;
    logic        d, sn, rn;
    if (k == 0) return 3'b010;
    s = SEED;
    for (int i = 0; i < k; i++) s = {s[14:0], ^(s & 16'hB400)};
    d  = s[0];
    rn = (s[3:1] != 3'b000);
    sn = (s[6:4] != 3'b000);
    return {d, sn, rn};
  endfunction

  function automatic logic model_q(input logic [2:0] v);
    if (!v[0]) return 1'b0;
    if (!v[1]) return 1'b1;
    return v[2];
  endfunction

  function automatic bit bad_vec(input int m, input int k);
    logic [2:0] v;
    v = vec_of(k);
    case (m)
      1:       return model_q(v) == 1'b1;
      2:       return (v[0] == 1'b0) && (v[1] == 1'b0);
      3:       return k >= 7;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int count_bad(input int m, input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (bad_vec(m, k)) c++;
    return c;
  endfunction

  function automatic int first_bad(input int m, input int n);
    for (int k = 0; k < n; k++) if (bad_vec(m, k)) return k;
    return 0;
  endfunction

  task automatic run_a(input int m);
    int exp_err;
    exp_err = count_bad(m, NV);
    mode    = m;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("busy_after_start", 32'(busy_a), 32'd1);
    check("done_cleared", 32'(done_a), 32'd0);
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      check($sformatf("pins_m%0d_v%0d", m, k),
            32'({pins_a.dut_d, pins_a.dut_set_n, pins_a.dut_reset_n}), 32'(vec_of(k)));
    end
    @(posedge clk); #1;
    check("done_not_early", 32'(done_a), 32'd0);
    check("pins_idle_drain", 32'({pins_a.dut_d, pins_a.dut_set_n, pins_a.dut_reset_n}), 32'b011);
    @(posedge clk); #1;
    check($sformatf("done_m%0d", m), 32'(done_a), 32'd1);
    check($sformatf("busy_m%0d", m), 32'(busy_a), 32'd0);
    check($sformatf("pass_m%0d", m), 32'(pass_a), 32'(exp_err == 0));
    check($sformatf("err_m%0d", m), 32'(err_a), 32'(exp_err));
    check($sformatf("vcnt_m%0d", m), 32'(vcnt_a), 32'(NV));
    check($sformatf("first_m%0d", m), 32'(first_a), FE ? 32'(first_bad(m, NV)) : 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pins"}, 32'({pins_a.dut_d, pins_a.dut_set_n, pins_a.dut_reset_n}), 32'b011);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_pass"}, 32'(pass_a), 32'd0);
    check({tag, "_err"}, 32'(err_a), 32'd0);
    check({tag, "_vcnt"}, 32'(vcnt_a), 32'd0);
    check({tag, "_first"}, 32'(first_a), 32'd0);
  endtask

  initial begin
    int sat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    run_a(0);
    run_a(1);
    @(negedge clk);
    run_a(2);

    // Abort mid-run; the restart must replay the same stream.
    @(negedge clk);
    mode    = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("abort");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_a(0);

    @(negedge clk);
    run_a(3);

    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (NVB + 1) @(posedge clk);
    #1 check("b_done_not_early", 32'(done_b), 32'd0);
    @(posedge clk); #1;
    sat = count_bad(1, NVB);
    if (sat > 3) sat = 3;
    check("b_done", 32'(done_b), 32'd1);
    check("b_err_sat", 32'(err_b), 32'(sat));
    check("b_pass", 32'(pass_b), 32'(sat == 0));
    check("b_vcnt", 32'(vcnt_b), 32'(NVB));
    check("b_first", 32'(first_b), FE ? 32'(first_bad(1, NVB)) : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
